tile_map: RTL and testbench

TILE_MAP -- requirements
Module: tile_map

---
 rtl/tile_map_pkg.sv | 29 ++
 rtl/tile_ram.sv | 63 ++++++
 rtl/tile_map.sv | 170 +++++++++++++++++
 tb/tb_tile_map.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_pkg.sv
// Shared geometry, entity and FSM definitions for the tile map and its storage.
package tile_map_pkg;

  localparam int GRID_COLS = 20;
  localparam int GRID_ROWS = 15;
  localparam int H_SQUARE  = 32;
  localparam int V_SQUARE  = 32;
  localparam int ENT_W     = 4;
  localparam int IDX_W     = 9;

  localparam logic [ENT_W-1:0] ENT_NOTHING = 4'd0;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PENDING = 2'd2,
    ST_COPY    = 2'd3
  } mapState_e;

  // Row-major linear tile index, truncated to the index counter width.
  function automatic logic [IDX_W-1:0] tileIndex(input logic [9:0] row,
                                                 input logic [9:0] col,
                                                 input int cols);
    int lin;
    lin = int'(row) * cols + int'(col);
    return lin[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/tile_ram.sv
// Double-banked tile storage: async display read, sync read for copy, sync write.
module tile_ram #(
  parameter int DEPTH = 300,
  parameter int ENT_W = 4,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             dispBank,
  input  logic [AW-1:0]    dispAddr,
  output logic [ENT_W-1:0] dispData,
  input  logic             rdBank,
  input  logic [AW-1:0]    rdAddr,
  output logic [ENT_W-1:0] rdData,
  input  logic             wrEn,
  input  logic             wrBoth,
  input  logic             wrBank,
  input  logic [AW-1:0]    wrAddr,
  input  logic [ENT_W-1:0] wrData
);

  localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

  logic [ENT_W-1:0] bank0_r [DEPTH];
  logic [ENT_W-1:0] bank1_r [DEPTH];

  // Display read; addresses past the map read as empty.
  always_comb begin
    dispData = {ENT_W{1'b0}};
    if (dispAddr < LIMIT) begin
      if (dispBank) begin
        dispData = bank1_r[dispAddr];
      end else begin
        dispData = bank0_r[dispAddr];
      end
    end else begin
      dispData = {ENT_W{1'b0}};
    end
  end

  // Registered read feeding the front-to-back copy.
  always_ff @(posedge clk) begin
    if (rdAddr < LIMIT) begin
      rdData <= rdBank ? bank1_r[rdAddr] : bank0_r[rdAddr];
    end else begin
      rdData <= {ENT_W{1'b0}};
    end
  end

  // Bank 0 write.
  always_ff @(posedge clk) begin
    if (wrEn && (wrAddr < LIMIT) && (wrBoth || !wrBank)) begin
      bank0_r[wrAddr] <= wrData;
    end
  end

  // Bank 1 write.
  always_ff @(posedge clk) begin
    if (wrEn && (wrAddr < LIMIT) && (wrBoth || wrBank)) begin
      bank1_r[wrAddr] <= wrData;
    end
  end

endmodule

// File: rtl/tile_map.sv
// Double-buffered tile map: writers fill the back buffer, a commit swaps it in on
// the next vsync fall and then resyncs the new back buffer from the new front.
module tile_map #(
  parameter int GRID_COLS = tile_map_pkg::GRID_COLS,
  parameter int GRID_ROWS = tile_map_pkg::GRID_ROWS,
  parameter int ENT_W     = tile_map_pkg::ENT_W
) (
  input  logic             iVGA_CLK,
  input  logic             sys_reset,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             vga_vsync,
  output logic [ENT_W-1:0] ent,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_col,
  input  logic [3:0]       wr_row,
  input  logic [ENT_W-1:0] wr_ent,
  input  logic             commit,
  output logic             commit_done
);

  import tile_map_pkg::*;

  localparam int                MAP_SIZE = GRID_COLS * GRID_ROWS;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MAP_SIZE - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
  localparam logic [9:0]        H_LIMIT  = 10'(GRID_COLS * H_SQUARE);
  localparam logic [9:0]        V_LIMIT  = 10'(GRID_ROWS * V_SQUARE);
  localparam logic [ENT_W-1:0]  ENT_ZERO = ENT_W'(ENT_NOTHING);

  mapState_e        state_r, nextState_s;
  logic [IDX_W-1:0] index_r, nextIndex_s;
  logic             frontSel_r, swap_s;
  logic             vsyncPrev_r, vsyncFall_s;
  logic             wrReady_r, commitDone_r, lastIdx_s;
  logic             wrFire_s, wrInRange_s, inScreen_s;
  logic [IDX_W-1:0] dispAddr_s, ramRdAddr_s, ramWrAddr_s;
  logic [ENT_W-1:0] dispData_s, rdData_s, ramWrData_s;
  logic             ramRdBank_s, ramWrEn_s, ramWrBoth_s, ramWrBank_s;

  assign vsyncFall_s = vsyncPrev_r && !vga_vsync;
  assign wr_ready    = wrReady_r;
  assign commit_done = commitDone_r;

  // Pixel-to-tile lookup on the front buffer, blanked outside the visible area.
  always_comb begin
    inScreen_s = (pix_x < H_LIMIT) && (pix_y < V_LIMIT);
    dispAddr_s = tileIndex(pix_y / 10'(V_SQUARE), pix_x / 10'(H_SQUARE), GRID_COLS);
    if (inScreen_s) begin
      ent = dispData_s;
    end else begin
      ent = ENT_ZERO;
    end
  end

  // Next-state and index sequencing.
  always_comb begin
    nextState_s = state_r;
    nextIndex_s = {IDX_W{1'b0}};
    swap_s      = 1'b0;
    lastIdx_s   = (index_r == LAST_IDX);
    case (state_r)
      ST_CLEAR, ST_COPY: begin
        if (lastIdx_s) begin
          nextState_s = ST_IDLE;
        end else begin
          nextIndex_s = index_r + IDX_ONE;
        end
      end
      ST_IDLE: begin
        if (commit) begin
          nextState_s = ST_PENDING;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (vsyncFall_s) begin
          nextState_s = ST_COPY;
          swap_s      = 1'b1;
        end else begin
          nextState_s = ST_PENDING;
        end
      end
      default: nextState_s = ST_CLEAR;
    endcase
  end

  // Storage port steering. The copy read runs one entry ahead of the write, so
  // the swap cycle prefetches entry 0 of the bank that is about to become front.
  always_comb begin
    wrInRange_s = (wr_col < 5'(GRID_COLS)) && (wr_row < 4'(GRID_ROWS));
    wrFire_s    = wr_valid && wrReady_r;
    ramWrEn_s   = 1'b0;
    ramWrBoth_s = 1'b0;
    ramWrBank_s = ~frontSel_r;
    ramWrAddr_s = index_r;
    ramWrData_s = ENT_ZERO;
    ramRdBank_s = frontSel_r;
    ramRdAddr_s = {IDX_W{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        ramWrEn_s   = 1'b1;
        ramWrBoth_s = 1'b1;
      end
      ST_IDLE: begin
        ramWrEn_s   = wrFire_s && wrInRange_s;
        ramWrAddr_s = tileIndex({6'd0, wr_row}, {5'd0, wr_col}, GRID_COLS);
        ramWrData_s = wr_ent;
      end
      ST_PENDING: begin
        ramRdBank_s = ~frontSel_r;
      end
      ST_COPY: begin
        ramWrEn_s   = 1'b1;
        ramWrData_s = rdData_s;
        if (lastIdx_s) begin
          ramRdAddr_s = {IDX_W{1'b0}};
        end else begin
          ramRdAddr_s = index_r + IDX_ONE;
        end
      end
      default: ramWrEn_s = 1'b0;
    endcase
  end

  // State, index, buffer select and registered handshake outputs.
  always_ff @(posedge iVGA_CLK) begin
    if (sys_reset) begin
      state_r      <= ST_CLEAR;
      index_r      <= {IDX_W{1'b0}};
      frontSel_r   <= 1'b0;
      vsyncPrev_r  <= 1'b1;
      wrReady_r    <= 1'b0;
      commitDone_r <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      index_r      <= nextIndex_s;
      vsyncPrev_r  <= vga_vsync;
      wrReady_r    <= (nextState_s == ST_IDLE);
      commitDone_r <= (state_r == ST_COPY) && lastIdx_s;
      if (swap_s) begin
        frontSel_r <= ~frontSel_r;
      end else begin
        frontSel_r <= frontSel_r;
      end
    end
  end

  tile_ram #(
    .DEPTH (MAP_SIZE),
    .ENT_W (ENT_W),
    .AW    (IDX_W)
  ) ramInst (
    .clk      (iVGA_CLK),
    .dispBank (frontSel_r),
    .dispAddr (dispAddr_s),
    .dispData (dispData_s),
    .rdBank   (ramRdBank_s),
    .rdAddr   (ramRdAddr_s),
    .rdData   (rdData_s),
    .wrEn     (ramWrEn_s),
    .wrBoth   (ramWrBoth_s),
    .wrBank   (ramWrBank_s),
    .wrAddr   (ramWrAddr_s),
    .wrData   (ramWrData_s)
  );

endmodule

// File: tb/tb_tile_map.sv
// Randomized bench for tile_map against a displayed/staged map model.
module tb_tile_map;

  localparam int COLS = 20;
  localparam int ROWS = 15;
  localparam int MAP  = COLS * ROWS;

  logic       iVGA_CLK = 1'b0;
  logic       sys_reset, vga_vsync, wr_valid, commit;
  logic [9:0] pix_x, pix_y;
  logic [3:0] ent, wr_ent, wr_row;
  logic [4:0] wr_col;
  logic       wr_ready, commit_done;

  int checks   = 0;
  int failures = 0;
  int shown  [MAP];
  int staged [MAP];

  tile_map #(.GRID_COLS(COLS), .GRID_ROWS(ROWS), .ENT_W(4)) dut (
    .iVGA_CLK    (iVGA_CLK),
    .sys_reset   (sys_reset),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .vga_vsync   (vga_vsync),
    .ent         (ent),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_ent      (wr_ent),
    .commit      (commit),
    .commit_done (commit_done)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic set_pix(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    #1;
  endtask

  // Model: displayed pixel value from the tile rules.
  function automatic int exp_ent(input int x, input int y);
    if (x >= 640 || y >= 480) return 0;
    return shown[(y / 32) * COLS + (x / 32)];
  endfunction

  function automatic void stage(input int col, input int row, input int e);
    if (col < COLS && row < ROWS) staged[row * COLS + col] = e;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < MAP; i++) begin
      shown[i]  = 0;
      staged[i] = 0;
    end
  endfunction

  task automatic do_write(input int col, input int row, input int e, input logic cmt);
    wr_col   = 5'(col);
    wr_row   = 4'(row);
    wr_ent   = 4'(e);
    wr_valid = 1'b1;
    commit   = cmt;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
  endtask

  // Drive one vsync falling edge; returns after the clock edge that samples it.
  task automatic vsync_fall();
    vga_vsync = 1'b0;
    tick();
    vga_vsync = 1'b1;
  endtask

  // Ticks until commit_done (bounded); n = -1 on timeout. busy counts cycles
  // before done where wr_ready was not low.
  task automatic wait_done(output int n, output int busy);
    n    = -1;
    busy = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (commit_done === 1'b1) begin
        n = i;
        return;
      end
      if (wr_ready !== 1'b0) busy++;
    end
  endtask

  // Counts tiles whose displayed value disagrees with the model.
  task automatic scan_map(output int bad);
    bad = 0;
    for (int i = 0; i < MAP; i++) begin
      @(posedge iVGA_CLK);
      #2;
      pix_x = 10'((i % COLS) * 32 + int'($urandom_range(31, 0)));
      pix_y = 10'((i / COLS) * 32 + int'($urandom_range(31, 0)));
      #2;
      if (ent !== 4'(shown[i])) bad++;
    end
  endtask

  // Counts reset-to-ready cycles; sawDone counts commit_done highs meanwhile.
  task automatic wait_ready(output int n, output int sawDone);
    n       = -1;
    sawDone = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (commit_done !== 1'b0) sawDone++;
      if (wr_ready === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int n, d, bad;
    sys_reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b want 0", wr_ready);
    end
    checks++;
    if (commit_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", commit_done);
    end
    sys_reset = 1'b0;
    wait_ready(n, d);
    checks++;
    if (n !== 300) begin
      failures++;
      $display("FAIL clear_latency: got %0d want 300", n);
    end
    model_clear();
    scan_map(bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clear_map: got %0d bad tiles want 0", bad);
    end
  endtask

  task automatic test_write_no_commit();
    do_write(3, 2, 5, 1'b0);
    stage(3, 2, 5);
    for (int f = 0; f < 2; f++) begin
      repeat (20) tick();
      vsync_fall();
      set_pix(100, 70);
      checks++;
      if (ent !== 4'(exp_ent(100, 70))) begin
        failures++;
        $display("FAIL nocommit_ent: frame %0d got %0d want %0d", f, ent, exp_ent(100, 70));
      end
      checks++;
      if (wr_ready !== 1'b1) begin
        failures++;
        $display("FAIL nocommit_ready: frame %0d got %b want 1", f, wr_ready);
      end
    end
  endtask

  task automatic test_commit();
    int n, busy, bad;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    repeat ($urandom_range(30, 5)) tick();
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL pending_ready: got %b want 0", wr_ready);
    end
    set_pix(100, 70);
    checks++;
    if (ent !== 4'(exp_ent(100, 70))) begin
      failures++;
      $display("FAIL pending_front: got %0d want %0d", ent, exp_ent(100, 70));
    end
    vsync_fall();
    shown = staged;
    set_pix(100, 70);
    checks++;
    if (ent !== 4'd5) begin
      failures++;
      $display("FAIL swap_ent: got %0d want 5", ent);
    end
    set_pix(95, 70);
    checks++;
    if (ent !== 4'(exp_ent(95, 70))) begin
      failures++;
      $display("FAIL swap_left: got %0d want %0d", ent, exp_ent(95, 70));
    end
    wait_done(n, busy);
    checks++;
    if (n !== 300 || busy !== 0) begin
      failures++;
      $display("FAIL copy_done: got n=%0d busy=%0d want n=300 busy=0", n, busy);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_ready: got %b want 1", wr_ready);
    end
    tick();
    checks++;
    if (commit_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: got %b want 0", commit_done);
    end
    scan_map(bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL commit_map: got %0d bad tiles want 0", bad);
    end
  endtask

  task automatic test_out_of_range();
    int n, busy, bad, x, y;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_ready: got %b want 1", wr_ready);
    end
    do_write(25, 2, 9, 1'b0);
    do_write(0, 15, 11, 1'b0);
    do_write(31, 14, 6, 1'b0);
    stage(25, 2, 9);
    stage(0, 15, 11);
    stage(31, 14, 6);
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL oor_accept: got %b want 1", wr_ready);
    end
    do_write(0, 0, 0, 1'b1);
    repeat (3) tick();
    vsync_fall();
    shown = staged;
    wait_done(n, busy);
    checks++;
    if (n !== 300) begin
      failures++;
      $display("FAIL oor_done: got %0d want 300", n);
    end
    scan_map(bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL oor_map: got %0d bad tiles want 0", bad);
    end
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        x = 640 + int'($urandom_range(383, 0));
        y = int'($urandom_range(479, 0));
      end else begin
        x = int'($urandom_range(639, 0));
        y = 480 + int'($urandom_range(543, 0));
      end
      if (k == 0) begin
        x = 736;
        y = 40;
      end
      set_pix(x, y);
      checks++;
      if (ent !== 4'd0) begin
        failures++;
        $display("FAIL offscreen: (%0d,%0d) got %0d want 0", x, y, ent);
      end
    end
  endtask

  task automatic test_same_cycle();
    int n, busy, bad, viol;
    do_write(0, 0, 7, 1'b1);
    stage(0, 0, 7);
    checks++;
    if (wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL same_pending: got %b want 0", wr_ready);
    end
    do_write(1, 0, 9, 1'b1);
    repeat (4) tick();
    vsync_fall();
    shown = staged;
    wait_done(n, busy);
    checks++;
    if (n !== 300 || busy !== 0) begin
      failures++;
      $display("FAIL same_done: got n=%0d busy=%0d want n=300 busy=0", n, busy);
    end
    set_pix(5, 5);
    checks++;
    if (ent !== 4'd7) begin
      failures++;
      $display("FAIL same_ent: got %0d want 7", ent);
    end
    set_pix(40, 5);
    checks++;
    if (ent !== 4'(exp_ent(40, 5))) begin
      failures++;
      $display("FAIL pending_write: got %0d want %0d", ent, exp_ent(40, 5));
    end
    viol = 0;
    repeat (10) tick();
    vsync_fall();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ready !== 1'b1 || commit_done !== 1'b0) viol++;
    end
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL extra_swap: got %0d bad cycles want 0", viol);
    end
    scan_map(bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL same_map: got %0d bad tiles want 0", bad);
    end
  endtask

  task automatic test_random();
    int n, busy, bad, viol, cnt, col, row, e;
    for (int r = 0; r < 4; r++) begin
      cnt = int'($urandom_range(25, 5));
      for (int w = 0; w < cnt; w++) begin
        col = int'($urandom_range(23, 0));
        row = int'($urandom_range(15, 0));
        e   = int'($urandom_range(15, 0));
        do_write(col, row, e, (w == cnt - 1) ? 1'b1 : 1'b0);
        stage(col, row, e);
        repeat ($urandom_range(2, 0)) tick();
      end
      viol = 0;
      for (int p = 0; p < int'($urandom_range(12, 3)); p++) begin
        if (wr_ready !== 1'b0) viol++;
        do_write(int'($urandom_range(19, 0)), int'($urandom_range(14, 0)),
                 int'($urandom_range(15, 1)), 1'($urandom_range(1, 0)));
      end
      checks++;
      if (viol !== 0) begin
        failures++;
        $display("FAIL rand_pending: round %0d got %0d ready cycles want 0", r, viol);
      end
      vsync_fall();
      shown = staged;
      wait_done(n, busy);
      checks++;
      if (n !== 300 || busy !== 0) begin
        failures++;
        $display("FAIL rand_done: round %0d got n=%0d busy=%0d want 300/0", r, n, busy);
      end
      scan_map(bad);
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rand_map: round %0d got %0d bad tiles want 0", r, bad);
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int n, d, bad;
    do_write(4, 4, 12, 1'b0);
    do_write(19, 14, 3, 1'b1);
    repeat (2) tick();
    vsync_fall();
    repeat (149) tick();
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || commit_done !== 1'b0) begin
      failures++;
      $display("FAIL midcopy_reset: got ready=%b done=%b want 0/0", wr_ready, commit_done);
    end
    wait_ready(n, d);
    checks++;
    if (n !== 300 || d !== 0) begin
      failures++;
      $display("FAIL midcopy_clear: got n=%0d done=%0d want 300/0", n, d);
    end
    model_clear();
    scan_map(bad);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midcopy_map: got %0d bad tiles want 0", bad);
    end
  endtask

  initial begin
    sys_reset = 1'b1;
    vga_vsync = 1'b1;
    wr_valid  = 1'b0;
    commit    = 1'b0;
    wr_col    = 5'd0;
    wr_row    = 4'd0;
    wr_ent    = 4'd0;
    pix_x     = 10'd0;
    pix_y     = 10'd0;
    test_reset();
    test_write_no_commit();
    test_commit();
    test_out_of_range();
    test_same_cycle();
    test_random();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
